alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Takes two WIDTH-bit operands and a 3-bit opcode through a valid/ready input port and returns a registered 2*WIDTH-bit result with status flags through a valid/ready output port. Adds XOR, shift, and a multi-cycle iterative multiply. Sits between an operand source and a result consumer, and tolerates backpressure on both sides.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 2. Result width is 2*WIDTH.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned; also the shift amount for SHL.
- s  in  3  opcode.
- in_valid  in  1  a/b/s are valid.
- in_ready  out  1  block accepts the operation this cycle.
- y  out  2*WIDTH  result.
- zero  out  1  y == 0.
- carry  out  1  ADD carry-out or SUB borrow; 0 for all other ops.
- err  out  1  reserved opcode was executed.
- out_valid  out  1  y and the flags are valid.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- Opcodes:
  - 000 ADD: y = a + b, zero-extended.
  - 001 SUB: y = a − b, as a (WIDTH+1)-bit two's-complement value sign-extended to 2*WIDTH.
  - 010 AND, 011 OR, 100 XOR: zero-extended.
  - 101 MUL: y = a * b, unsigned, full 2*WIDTH bits.
  - 110 SHL: y = zext(a) << (b mod 2*WIDTH).
  - 111 reserved: y = 0, err = 1.
- Carry flag:
  - ADD: carry = bit WIDTH of the sum.
  - SUB: carry = 1 iff a < b (borrow).
- Operands and opcode are captured on accept; later changes on a, b or s have no effect on an operation in flight.
- FSM states:
  - IDLE: no result held; in_ready = 1.
  - BUSY: MUL iterating.
  - HOLD: out_valid = 1, result held.
- Transitions:
  - IDLE, accept of a non-MUL op → HOLD.
  - IDLE, accept of MUL → BUSY.
  - BUSY, after WIDTH iterations → HOLD.
  - HOLD, out_ready = 1 and no new accept → IDLE.
  - HOLD, out_ready = 1 with a simultaneous accept → HOLD (non-MUL) or BUSY (MUL).
- in_ready = (state == IDLE) || (state == HOLD && out_ready). This is a combinational path from out_ready and is intentional.
- Exactly one operation is in flight at a time. There is no queueing.
- In HOLD with out_ready = 0, y and all flags stay stable and in_ready = 0.

## Timing
- Accept occurs on a rising edge with in_valid && in_ready. Transfer out occurs on a rising edge with out_valid && out_ready.
- Non-MUL latency: out_valid is high in the cycle after accept (1 cycle).
- MUL latency: accept at edge 0, WIDTH shift-add iterations, out_valid high after edge WIDTH+1. In BUSY, in_ready = 0.
- Sustained throughput for non-MUL ops is 1 per cycle when out_ready is held high.
- Reset values: state = IDLE, y = 0, zero = 0, carry = 0, err = 0, out_valid = 0. in_ready = 1 once reset deasserts.
- Reset asserted mid-MUL or during HOLD aborts immediately and asynchronously. The pending result is discarded and never presented.
- in_valid = 0 never changes state.
- out_ready is ignored when out_valid = 0.

## Structure
- Package alu_pkg holds:
  - the opcode enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_SHL, OP_RSVD;
  - the state enum: ST_IDLE, ST_BUSY, ST_HOLD.
- Sub-module alu_mul_seq: iterative unsigned shift-add multiplier, parameter WIDTH.
  - Ports: clk, reset, start, a, b, done, p.
  - p is valid in the cycle done = 1, exactly WIDTH cycles after start.
- The top level holds the FSM, the single-cycle datapath, the output register and the flag generation.

## Test plan
All scenarios use WIDTH = 4.
- ADD a=15, b=15, out_ready=1 → one cycle later y=0x1E, carry=1, zero=0, err=0.
- SUB a=3, b=5 → y=0xFE, carry=1. SUB a=5, b=5 → y=0x00, zero=1, carry=0.
- MUL a=15, b=15 accepted at edge 0 → in_ready low through BUSY; y=0xE1 with out_valid after edge 5. MUL a=0, b=9 → y=0, zero=1.
- Backpressure: SHL a=9, b=3 (y=0x48), out_ready held low 3 cycles → y stable and in_ready=0 throughout. Raising out_ready together with a new in_valid (XOR a=0xA, b=0x5) → transfer and accept on the same edge; next y=0x0F.
- Opcode 111 with a=7, b=7 → y=0, err=1, zero=1. The following ADD 1+1 → y=2, err=0.
- Assert reset 2 cycles into MUL 12*11 → out_valid=0 immediately, y=0; after release in_ready=1, and a fresh ADD 2+3 yields y=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SHL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the operand source, alu_pipe and the result consumer.
interface alu_pipe_if #(parameter int WIDTH = 4);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         s;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] y;
  logic               zero;
  logic               carry;
  logic               err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output a, b, s, in_valid, out_ready,
    input  in_ready, y, zero, carry, err, out_valid
  );

  modport slave (
    input  a, b, s, in_valid, out_ready,
    output in_ready, y, zero, carry, err, out_valid
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, p valid while done is high.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
      active <= 1'b1;
    end else if (active) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        active <= 1'b0;
      end
    end
  end

  // Counter reaching zero while active marks the single done cycle.
  assign done = active && (cnt == '0);
  assign p    = acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops register straight into the result slot, MUL goes through alu_mul_seq.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  import alu_pkg::*;

  localparam int unsigned W2 = 2 * WIDTH;

  state_e state, state_next;
  op_e    op;

  logic               in_ready;
  logic               accept;
  logic               mul_start;
  logic               load_alu;
  logic               load_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] alu_y;
  logic               alu_carry;
  logic               alu_err;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [31:0]        shamt;

  logic [2*WIDTH-1:0] y_reg;
  logic               zero_reg;
  logic               carry_reg;
  logic               err_reg;

  assign op    = op_e'(bus.s);
  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt = 32'(bus.b) % W2;

  always_comb begin
    alu_y     = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y     = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      // The (WIDTH+1)-bit difference's top bit is both the sign and the borrow.
      OP_SUB: begin
        alu_y     = {{(WIDTH-1){diff[WIDTH]}}, diff};
        alu_carry = diff[WIDTH];
      end
      OP_AND:  alu_y = {{WIDTH{1'b0}}, bus.a & bus.b};
      OP_OR:   alu_y = {{WIDTH{1'b0}}, bus.a | bus.b};
      OP_XOR:  alu_y = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      OP_MUL:  alu_y = '0;
      OP_SHL:  alu_y = {{WIDTH{1'b0}}, bus.a} << shamt;
      OP_RSVD: alu_err = 1'b1;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    mul_start  = 1'b0;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: begin
        if (mul_done) begin
          state_next = ST_HOLD;
          load_mul   = 1'b1;
        end
      end
      ST_HOLD: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A new accept in HOLD overrides the drain-to-IDLE decided above.
    accept = bus.in_valid && in_ready;
    if (accept) begin
      if (op == OP_MUL) begin
        state_next = ST_BUSY;
        mul_start  = 1'b1;
      end else begin
        state_next = ST_HOLD;
        load_alu   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_reg     <= '0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (load_alu) begin
      y_reg     <= alu_y;
      zero_reg  <= (alu_y == '0);
      carry_reg <= alu_carry;
      err_reg   <= alu_err;
    end else if (load_mul) begin
      y_reg     <= mul_p;
      zero_reg  <= (mul_p == '0);
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.y         = y_reg;
  assign bus.zero      = zero_reg;
  assign bus.carry     = carry_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=4: expectations queued at issue, popped when results appear.
module tb_alu_pipe;

  localparam int W = 4;

  typedef struct packed {
    logic [2*W-1:0] y;
    logic           zero;
    logic           carry;
    logic           err;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];

  function automatic res_t model(input int unsigned op, input int unsigned a, input int unsigned b);
    int unsigned r;
    res_t e;
    e = '0;
    r = 0;
    case (op)
      0: begin r = a + b; e.carry = (r > 15); end
      1: begin r = (a >= b) ? a - b : 256 - (b - a); e.carry = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * b;
      6: r = (a << (b % 8)) & 255;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.y    = r[7:0];
    e.zero = (r == 0);
    return e;
  endfunction

  function automatic res_t sample();
    return {bus.y, bus.zero, bus.carry, bus.err};
  endfunction

  // Call at posedge+1; returns one posedge+1 after the accept edge with inputs scrambled.
  task automatic issue(input int unsigned op, input int unsigned a, input int unsigned b, output int waited);
    bus.s        = op[2:0];
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.in_valid = 1'b1;
    waited       = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        waited = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.s        = 3'($urandom);
  endtask

  task automatic collect(output res_t got, output int waited);
    got    = '0;
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        waited = i;
        got    = sample();
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.s         = '0;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    tests++;
    if (sample() !== res_t'('0)) begin
      fails++; $display("FAIL reset_result: got y=%h zce=%b%b%b want all zero", bus.y, bus.zero, bus.carry, bus.err);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL idle_no_valid: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_add();
    res_t got, exp;
    int   wi, wo;
    bus.out_ready = 1'b1;
    sb.push_back(model(0, 15, 15));
    issue(0, 15, 15, wi);
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wi != 0 || wo != 0 || got !== exp) begin
      fails++; $display("FAIL add_15_15: got y=%h zce=%b%b%b wait=%0d/%0d want y=%h zce=%b%b%b wait=0/0",
                        got.y, got.zero, got.carry, got.err, wi, wo, exp.y, exp.zero, exp.carry, exp.err);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL add_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    int unsigned av[2] = '{3, 5};
    int unsigned bv[2] = '{5, 5};
    res_t got, exp;
    int   wi, wo;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(1, av[i], bv[i]));
      issue(1, av[i], bv[i], wi);
      collect(got, wo);
      exp = sb.pop_front();
      tests++;
      if (wo != 0 || got !== exp) begin
        fails++; $display("FAIL sub_%0d_%0d: got y=%h zce=%b%b%b wait=%0d want y=%h zce=%b%b%b wait=0",
                          av[i], bv[i], got.y, got.zero, got.carry, got.err, wo, exp.y, exp.zero, exp.carry, exp.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    res_t got, exp;
    int   wi, wo;
    bus.out_ready = 1'b1;
    sb.push_back(model(5, 15, 15));
    issue(5, 15, 15, wi);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL mul_busy_%0d: got in_ready=%b out_valid=%b want 0/0", k, bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1;
    end
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wo != 0 || got !== exp) begin
      fails++; $display("FAIL mul_15_15: got y=%h zce=%b%b%b wait=%0d want y=%h zce=%b%b%b wait=0",
                        got.y, got.zero, got.carry, got.err, wo, exp.y, exp.zero, exp.carry, exp.err);
    end
    @(posedge clk);
    #1;
    sb.push_back(model(5, 0, 9));
    issue(5, 0, 9, wi);
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wo != 5 || got !== exp) begin
      fails++; $display("FAIL mul_0_9: got y=%h zce=%b%b%b wait=%0d want y=%h zce=%b%b%b wait=5",
                        got.y, got.zero, got.carry, got.err, wo, exp.y, exp.zero, exp.carry, exp.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    res_t got, exp;
    int   wi, wo;
    bus.out_ready = 1'b0;
    sb.push_back(model(6, 9, 3));
    issue(6, 9, 3, wi);
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wo != 0 || got !== exp) begin
      fails++; $display("FAIL shl_9_3: got y=%h zce=%b%b%b wait=%0d want y=%h zce=%b%b%b wait=0",
                        got.y, got.zero, got.carry, got.err, wo, exp.y, exp.zero, exp.carry, exp.err);
    end
    // A competing request during the stall must not be taken.
    bus.s        = 3'b000;
    bus.a        = 4'd1;
    bus.b        = 4'd1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (sample() !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_stable_%0d: got y=%h out_valid=%b in_ready=%b want y=%h 1/0",
                          k, bus.y, bus.out_valid, bus.in_ready, exp.y);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    sb.push_back(model(4, 10, 5));
    issue(4, 10, 5, wi);
    tests++;
    if (wi != 0) begin
      fails++; $display("FAIL xor_same_edge_accept: got wait=%0d want 0", wi);
    end
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wo != 0 || got !== exp) begin
      fails++; $display("FAIL xor_a_5: got y=%h zce=%b%b%b wait=%0d want y=%h zce=%b%b%b wait=0",
                        got.y, got.zero, got.carry, got.err, wo, exp.y, exp.zero, exp.carry, exp.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reserved();
    int unsigned ops[2] = '{7, 0};
    int unsigned av[2]  = '{7, 1};
    res_t got, exp;
    int   wi, wo;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(ops[i], av[i], av[i]));
      issue(ops[i], av[i], av[i], wi);
      collect(got, wo);
      exp = sb.pop_front();
      tests++;
      if (wi != 0 || wo != 0 || got !== exp) begin
        fails++; $display("FAIL rsvd_seq_%0d: got y=%h zce=%b%b%b want y=%h zce=%b%b%b",
                          i, got.y, got.zero, got.carry, got.err, exp.y, exp.zero, exp.carry, exp.err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int unsigned ops[8] = '{0, 1, 2, 3, 4, 6, 1, 6};
    int unsigned a, b;
    res_t got, exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      sb.push_back(model(ops[i], a, b));
      bus.s        = ops[i][2:0];
      bus.a        = a[W-1:0];
      bus.b        = b[W-1:0];
      bus.in_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk);
      #1;
      got = sample();
      exp = sb.pop_front();
      tests++;
      if (bus.out_valid !== 1'b1 || got !== exp) begin
        fails++; $display("FAIL b2b_%0d op=%0d a=%0d b=%0d: got y=%h zce=%b%b%b v=%b want y=%h zce=%b%b%b v=1",
                          i, ops[i], a, b, got.y, got.zero, got.carry, got.err, bus.out_valid,
                          exp.y, exp.zero, exp.carry, exp.err);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    res_t got, exp;
    int   wi, wo, seen;
    bus.out_ready = 1'b1;
    issue(5, 12, 11, wi);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.y !== 8'h00) begin
      fails++; $display("FAIL abort_async: got out_valid=%b y=%h want 0/00", bus.out_valid, bus.y);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL abort_discard: got %0d valid cycles want 0", seen);
    end
    sb.push_back(model(0, 2, 3));
    issue(0, 2, 3, wi);
    collect(got, wo);
    exp = sb.pop_front();
    tests++;
    if (wi != 0 || wo != 0 || got !== exp) begin
      fails++; $display("FAIL add_after_abort: got y=%h zce=%b%b%b want y=%h zce=%b%b%b",
                        got.y, got.zero, got.carry, got.err, exp.y, exp.zero, exp.carry, exp.err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "tb_alu_pipe time limit");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_reserved();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
